npc_seq: RTL and testbench

- Parametrised successor to the combinational next-PC logic, with the PC register folded in.
- Holds the architectural fetch PC and computes the next PC for sequential, conditional-branch, jump and register-jump flow, and for interrupt and eret redirects.
- Adds stall support: a redirect requested during a stall is buffered and applied on the first unstalled edge.
- Sits between the decode/compare logic and the instruction memory address port.

---
 rtl/npc_pkg.sv | 19 +
 rtl/npc_target.sv | 69 ++++++
 rtl/npc_seq.sv | 149 ++++++++++++++
 tb/tb_npc_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared encodings and defaults for the next-PC sequencer.
package npc_pkg;

    // pc_sel encodings; the remaining codes fall back to sequential flow
    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b011;
    localparam logic [2:0] NPC_BRN = 3'b100;

    // Sequencer FSM states
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;

    // Default reset PC and exception entry vector
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/npc_target.sv
// Combinational raw next-PC selection and redirect detection.
module npc_target
    import npc_pkg::*;
#(
    parameter int unsigned     XLEN   = 32,
    parameter int unsigned     IDX_W  = 26,
    parameter logic [XLEN-1:0] EXC_PC = EXC_PC_DEF
) (
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  pc_plus4_i,
    input  logic [2:0]       pc_sel_i,
    input  logic             cond_i,
    input  logic [IDX_W-1:0] imm_i,
    input  logic [XLEN-1:0]  gpr_i,
    input  logic             intreq_i,
    input  logic             eret_i,
    input  logic [XLEN-1:0]  epc_i,
    output logic [XLEN-1:0]  raw_tgt_o,
    output logic             redirect_o
);

    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] j_tgt;

    // Branch base is the branch's own pc, not pc+4
    assign br_tgt = pc_i + {{(XLEN-18){imm_i[15]}}, imm_i[15:0], 2'b00};
    assign j_tgt  = {pc_plus4_i[XLEN-1:28], imm_i, 2'b00};

    // Priority: interrupt, then eret, then pc_sel decode
    always_comb begin
        raw_tgt_o  = pc_plus4_i;
        redirect_o = 1'b0;
        if (intreq_i) begin
            raw_tgt_o  = EXC_PC;
            redirect_o = 1'b1;
        end else if (eret_i) begin
            raw_tgt_o  = epc_i;
            redirect_o = 1'b1;
        end else begin
            case (pc_sel_i)
                NPC_BR: begin
                    if (cond_i) begin
                        raw_tgt_o  = br_tgt;
                        redirect_o = 1'b1;
                    end
                end
                NPC_BRN: begin
                    if (!cond_i) begin
                        raw_tgt_o  = br_tgt;
                        redirect_o = 1'b1;
                    end
                end
                NPC_J: begin
                    raw_tgt_o  = j_tgt;
                    redirect_o = 1'b1;
                end
                NPC_JR: begin
                    raw_tgt_o  = gpr_i;
                    redirect_o = 1'b1;
                end
                default: begin
                    raw_tgt_o  = pc_plus4_i;
                    redirect_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/npc_seq.sv
// Fetch PC register with next-PC selection and stall-tolerant redirect buffering.
// A redirect requested while stalled is held in pend_tgt and applied on the first
// unstalled edge. Optional macro NPC_ALIGN_CHK_EN adds the adel_o misaligned-PC flag.
module npc_seq
    import npc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     IDX_W    = 26,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] EXC_PC   = EXC_PC_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic [2:0]       pc_sel_i,
    input  logic             cond_i,
    input  logic [IDX_W-1:0] imm_i,
    input  logic [XLEN-1:0]  gpr_i,
    input  logic             intreq_i,
    input  logic             eret_i,
    input  logic [XLEN-1:0]  epc_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic [XLEN-1:0]  npc_o,
`ifdef NPC_ALIGN_CHK_EN
    output logic             adel_o,
`endif
    output logic             pend_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] raw_tgt;
    logic            redirect;
    logic [XLEN-1:0] rel_tgt;

`ifdef NPC_ALIGN_CHK_EN
    logic adel_q, adel_d;
    logic pc_load;
`endif

    assign pc_plus4_o = pc_q + XLEN'(4);
    assign pc_o       = pc_q;
    assign pend_o     = (state_q == S_PEND);

    // A fresh interrupt overrides the buffered target
    assign rel_tgt = intreq_i ? EXC_PC : pend_tgt_q;

    npc_target #(
        .XLEN   (XLEN),
        .IDX_W  (IDX_W),
        .EXC_PC (EXC_PC)
    ) u_npc_target (
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4_o),
        .pc_sel_i   (pc_sel_i),
        .cond_i     (cond_i),
        .imm_i      (imm_i),
        .gpr_i      (gpr_i),
        .intreq_i   (intreq_i),
        .eret_i     (eret_i),
        .epc_i      (epc_i),
        .raw_tgt_o  (raw_tgt),
        .redirect_o (redirect)
    );

    // Next-state logic for PC, FSM and buffered redirect target
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        npc_o      = raw_tgt;
`ifdef NPC_ALIGN_CHK_EN
        pc_load    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!stall_i) begin
                    pc_d = raw_tgt;
`ifdef NPC_ALIGN_CHK_EN
                    pc_load = 1'b1;
`endif
                end else if (redirect) begin
                    pend_tgt_d = raw_tgt;
                    state_d    = S_PEND;
                end
            end
            S_PEND: begin
                npc_o = rel_tgt;
                if (stall_i) begin
                    // Only an interrupt may replace the buffered target
                    pend_tgt_d = rel_tgt;
                end else begin
                    pc_d    = rel_tgt;
                    state_d = S_IDLE;
`ifdef NPC_ALIGN_CHK_EN
                    pc_load = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef NPC_ALIGN_CHK_EN
        // A misaligned PC is replaced by the exception vector regardless of stall
        if (adel_q) begin
            pc_d       = EXC_PC;
            npc_o      = EXC_PC;
            state_d    = S_IDLE;
            pend_tgt_d = '0;
            pc_load    = 1'b0;
        end
`endif
    end

`ifdef NPC_ALIGN_CHK_EN
    // Flag a non-interrupt load of a misaligned PC
    always_comb begin
        adel_d = pc_load && !intreq_i && (pc_d[1:0] != 2'b00);
    end

    // Misaligned-fetch flag register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= adel_d;
        end
    end

    assign adel_o = adel_q;
`endif

    // PC, FSM state and buffered target registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q       <= RESET_PC;
            state_q    <= S_IDLE;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule

// File: tb/tb_npc_seq.sv
// Directed self-checking bench for npc_seq (default build).
module tb_npc_seq;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_sel;
    logic        cond;
    logic [25:0] imm;
    logic [31:0] gpr;
    logic        intreq;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic        pend;
`ifdef NPC_ALIGN_CHK_EN
    logic        adel;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    npc_seq u_dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .stall_i    (stall),
        .pc_sel_i   (pc_sel),
        .cond_i     (cond),
        .imm_i      (imm),
        .gpr_i      (gpr),
        .intreq_i   (intreq),
        .eret_i     (eret),
        .epc_i      (epc),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4),
        .npc_o      (npc),
`ifdef NPC_ALIGN_CHK_EN
        .adel_o     (adel),
`endif
        .pend_o     (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic [2:0] sel, input logic c,
                          input logic [25:0] im, input logic [31:0] g);
        stall  = s;
        pc_sel = sel;
        cond   = c;
        imm    = im;
        gpr    = g;
    endtask

    initial begin
        reset  = 1'b1;
        intreq = 1'b0;
        eret   = 1'b0;
        epc    = '0;
        set_in(1'b0, 3'b000, 1'b0, 26'h0, 32'h0);
        #1;
        check("reset_pc", pc, 32'h0000_3000);
        check("reset_pend", {31'b0, pend}, 32'h0);
        check("reset_pc_plus4", pc_plus4, 32'h0000_3004);
        check("reset_npc", npc, 32'h0000_3004);
        @(negedge clk);
        reset = 1'b0;

        // Sequential flow
        step(); check("seq1", pc, 32'h0000_3004);
        step(); check("seq2", pc, 32'h0000_3008);
        step(); check("seq3", pc, 32'h0000_300C);
        step(); check("seq4", pc, 32'h0000_3010);

        // Taken branch, offset -1 word from the branch pc itself
        set_in(1'b0, 3'b001, 1'b1, 26'h000_FFFF, 32'h0);
        #1 check("br_taken_npc", npc, 32'h0000_300C);
        step(); check("br_taken_pc", pc, 32'h0000_300C);
        set_in(1'b0, 3'b000, 1'b0, 26'h0, 32'h0);
        step(); check("seq_back", pc, 32'h0000_3010);
        set_in(1'b0, 3'b001, 1'b0, 26'h000_FFFF, 32'h0);
        #1 check("br_untaken_npc", npc, 32'h0000_3014);
        step(); check("br_untaken_pc", pc, 32'h0000_3014);

        // Branch-if-not: taken on cond=0 (+4 words), falls through on cond=1
        set_in(1'b0, 3'b100, 1'b0, 26'h000_0004, 32'h0);
        step(); check("brn_taken", pc, 32'h0000_3024);
        set_in(1'b0, 3'b100, 1'b1, 26'h000_0004, 32'h0);
        step(); check("brn_untaken", pc, 32'h0000_3028);

        // Reserved pc_sel behaves as sequential
        set_in(1'b0, 3'b101, 1'b1, 26'h000_0004, 32'h0);
        step(); check("sel_reserved", pc, 32'h0000_302C);

        // Jump: upper bits of pc+4, index shifted left by 2
        set_in(1'b0, 3'b010, 1'b0, 26'h000_0D00, 32'h0);
        step(); check("jump", pc, 32'h0000_3400);

        // Buffered register jump across a 3-cycle stall
        set_in(1'b0, 3'b011, 1'b0, 26'h0, 32'h0000_3000);
        step(); check("jr", pc, 32'h0000_3000);
        set_in(1'b1, 3'b011, 1'b0, 26'h0, 32'h0000_3400);
        step();
        check("stall_pend", {31'b0, pend}, 32'h1);
        check("stall_pc_held", pc, 32'h0000_3000);
        check("stall_npc", npc, 32'h0000_3400);
        set_in(1'b1, 3'b000, 1'b0, 26'h0, 32'h0);
        step(); step();
        check("stall3_pc_held", pc, 32'h0000_3000);
        check("stall3_pend", {31'b0, pend}, 32'h1);
        set_in(1'b0, 3'b000, 1'b0, 26'h0, 32'h0);
        step();
        check("release_pc", pc, 32'h0000_3400);
        check("release_pend", {31'b0, pend}, 32'h0);

        // Same buffered jump, interrupt pulsed while stalled
        set_in(1'b0, 3'b011, 1'b0, 26'h0, 32'h0000_3000);
        step();
        set_in(1'b1, 3'b011, 1'b0, 26'h0, 32'h0000_3400);
        step();
        set_in(1'b1, 3'b000, 1'b0, 26'h0, 32'h0);
        intreq = 1'b1;
        #1 check("pend_int_npc", npc, 32'h0000_4180);
        step();
        intreq = 1'b0;
        #1 check("pend_int_buffered_npc", npc, 32'h0000_4180);
        check("pend_int_pc_held", pc, 32'h0000_3000);
        stall = 1'b0;
        step();
        check("pend_int_release", pc, 32'h0000_4180);
        check("pend_int_pend", {31'b0, pend}, 32'h0);

        // eret alone, then eret with intreq (intreq wins)
        eret = 1'b1;
        epc  = 32'h0000_3020;
        step(); check("eret", pc, 32'h0000_3020);
        intreq = 1'b1;
        epc    = 32'h0000_3040;
        step(); check("int_over_eret", pc, 32'h0000_4180);
        intreq = 1'b0;
        eret   = 1'b0;

        // Address wrap-around
        set_in(1'b0, 3'b011, 1'b0, 26'h0, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        set_in(1'b0, 3'b000, 1'b0, 26'h0, 32'h0);
        step(); check("wrap_seq", pc, 32'h0000_0000);

        // Reset while a redirect is buffered: takes effect without a clock edge
        set_in(1'b1, 3'b011, 1'b0, 26'h0, 32'h0000_3400);
        step();
        check("pre_reset_pend", {31'b0, pend}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_pc", pc, 32'h0000_3000);
        check("async_reset_pend", {31'b0, pend}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b0, 3'b000, 1'b0, 26'h0, 32'h0);
        step(); check("post_reset_seq", pc, 32'h0000_3004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
